uart_bus_master: RTL and testbench

//  Bus initiator driven by a serial byte stream: decodes read/write commands from an upstream UART

---
 rtl/uart_bus_master_pkg.sv | 17 +
 rtl/uart_bus_master_txser.sv | 48 ++++
 rtl/uart_bus_master.sv | 161 ++++++++++++++++
 tb/tb_uart_bus_master.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_master_pkg.sv
// Shared command/response codes and FSM state encoding for the UART bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBus,
    StResp
  } state_e;

endpackage

// File: rtl/uart_bus_master_txser.sv
// Response serializer: loads one byte or a 32-bit word (sent MSB first) and hands it out
// over a valid/ready byte stream. done pulses in the cycle the last byte is accepted.
module uart_bus_master_txser (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        load_four,
  input  logic [31:0] load_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [23:0] rest;
  logic [1:0]  left;

  assign done = tx_valid && tx_ready && (left == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rest     <= 24'h0;
      left     <= 2'd0;
    end else if (load) begin
      tx_valid <= 1'b1;
      if (load_four) begin
        tx_data <= load_data[31:24];
        rest    <= load_data[23:0];
        left    <= 2'd3;
      end else begin
        tx_data <= load_data[7:0];
        rest    <= 24'h0;
        left    <= 2'd0;
      end
    end else if (tx_valid && tx_ready) begin
      if (left == 2'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data <= rest[23:16];
        rest    <= {rest[15:0], 8'h00};
        left    <= left - 2'd1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Serial-command bus initiator: decodes read/write frames, runs one valid/ready bus transaction
// and streams the reply. Optional bus timeout: define UART_BUS_MASTER_BUS_TIMEOUT_EN.
module uart_bus_master
`ifdef UART_BUS_MASTER_BUS_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1024)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);
  import uart_bus_master_pkg::*;

  state_e      state;
  logic [1:0]  byte_cnt;
  logic        is_read;
  logic        cmd_ok;
  logic        timeout;
  logic        ser_load;
  logic        ser_four;
  logic [31:0] ser_data;
  logic        ser_done;

  assign mem_instr = 1'b0;
  assign busy      = (state != StIdle);
  assign cmd_ok    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);

`ifdef UART_BUS_MASTER_BUS_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset || !mem_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // mem_ready in the terminal cycle takes priority over the timeout.
  assign timeout = mem_valid && !mem_ready && (tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Serializer load is combinational so tx_valid rises the cycle after the deciding event.
  always_comb begin
    ser_load = 1'b0;
    ser_four = 1'b0;
    ser_data = {24'h0, RSP_NAK};
    if (state == StIdle && rx_valid && !cmd_ok) begin
      ser_load = 1'b1;
    end else if (state == StBus && mem_ready) begin
      ser_load = 1'b1;
      if (is_read) begin
        ser_four = 1'b1;
        ser_data = mem_rdata;
      end else begin
        ser_data = {24'h0, RSP_ACK};
      end
    end else if (state == StBus && timeout) begin
      ser_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      byte_cnt  <= 2'd0;
      is_read   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (rx_valid) begin
            if (cmd_ok) begin
              state    <= StAddr;
              is_read  <= (rx_data == CMD_READ);
              byte_cnt <= 2'd0;
            end else begin
              state <= StResp;
            end
          end
        end
        StAddr: begin
          if (rx_valid) begin
            mem_addr <= {mem_addr[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_read) begin
                state     <= StBus;
                mem_valid <= 1'b1;
                mem_wstrb <= 4'h0;
              end else begin
                state <= StData;
              end
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            mem_wdata <= {mem_wdata[23:0], rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= StBus;
              mem_valid <= 1'b1;
              mem_wstrb <= 4'hF;
            end
          end
        end
        StBus: begin
          if (mem_ready || timeout) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            state     <= StResp;
          end
        end
        StResp: begin
          if (ser_done) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
      // No backpressure on rx: bytes arriving while a transaction is in flight are lost.
      if (rx_valid && (state == StBus || state == StResp)) begin
        overrun <= 1'b1;
      end
    end
  end

  uart_bus_master_txser u_txser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_four (ser_four),
    .load_data (ser_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with bus/tx scoreboards and a latency-programmable responder.
// Build with UART_BUS_MASTER_BUS_TIMEOUT_EN to also exercise the bus timeout (TIMEOUT_CYCLES=16).
module tb_uart_bus_master;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_wdata;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_tx[$];
  bus_exp_t   exp_bus[$];

  int          rsp_lat = 0;
  logic        rsp_en = 1'b1;
  logic [31:0] rsp_data = 32'h0;
  int          wait_cnt = 0;
  int          valid_cycles = 0;

  always #5 clk = ~clk;

`ifdef UART_BUS_MASTER_BUS_TIMEOUT_EN
  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
`else
  uart_bus_master dut (
`endif
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Responder: asserts mem_ready after rsp_lat wait cycles of mem_valid.
  always @(posedge clk) begin
    #1;
    mem_ready = 1'b0;
    if (mem_valid && rsp_en && !reset) begin
      if (wait_cnt == rsp_lat) begin
        mem_ready = 1'b1;
        mem_rdata = rsp_data;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  logic        hold_v = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_wstrb;

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else if (mem_valid) begin
      valid_cycles++;
      if (hold_v) begin
        check("bus_addr_stable", mem_addr, hold_addr);
        check("bus_wdata_stable", mem_wdata, hold_wdata);
        check("bus_wstrb_stable", {28'h0, mem_wstrb}, {28'h0, hold_wstrb});
      end
      hold_v = 1'b1;
      hold_addr = mem_addr;
      hold_wdata = mem_wdata;
      hold_wstrb = mem_wstrb;
      if (mem_ready) begin
        hold_v = 1'b0;
        if (exp_bus.size() == 0) begin
          check("bus_unexpected_addr", mem_addr, 32'hxxxxxxxx);
        end else begin
          bus_exp_t e;
          e = exp_bus.pop_front();
          check("bus_addr", mem_addr, e.addr);
          check("bus_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
          if (e.chk_wdata) check("bus_wdata", mem_wdata, e.wdata);
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        check("tx_unexpected", {24'h0, tx_data}, 32'hxxxxxxxx);
      end else begin
        logic [7:0] eb;
        eb = exp_tx.pop_front();
        check("tx_byte", {24'h0, tx_data}, {24'h0, eb});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic has_d,
                            input logic [31:0] d);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (has_d) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic cw);
    bus_exp_t e;
    e.addr = a; e.wdata = d; e.wstrb = s; e.chk_wdata = cw;
    exp_bus.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || tx_valid || exp_tx.size() != 0) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_idle_timeout"}, {31'h0, k >= 500}, 32'h0);
  endtask

  task automatic wait_tx_valid(input string tag);
    int k;
    k = 0;
    while (!tx_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_txvalid_timeout"}, {31'h0, k >= 200}, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
    check({tag, "_mem_instr"}, {31'h0, mem_instr}, 32'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_tx.delete();
  endtask

  initial begin
    int vc0;
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    // Write frame, responder answers after one wait cycle.
    rsp_lat = 1;
    push_bus(32'h02000000, 32'h000000A5, 4'hF, 1'b1);
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h02000000, 1'b1, 32'h000000A5);
    check("wr_valid_after_last_byte", {31'h0, mem_valid}, 32'h1);
    wait_idle("wr");

    // Read frame, three wait cycles.
    rsp_lat = 3;
    rsp_data = 32'hDEADBEEF;
    push_bus(32'h00000010, 32'h0, 4'h0, 1'b0);
    push_tx_word(32'hDEADBEEF);
    send_frame(8'h52, 32'h00000010, 1'b0, 32'h0);
    wait_idle("rd");

    // Single-cycle transaction.
    rsp_lat = 0;
    rsp_data = 32'h12345678;
    push_bus(32'h80000004, 32'h0, 4'h0, 1'b0);
    push_tx_word(32'h12345678);
    send_frame(8'h52, 32'h80000004, 1'b0, 32'h0);
    wait_idle("rd1");

    // Bad command: NAK only, no bus activity, then a normal write.
    vc0 = valid_cycles;
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_idle("bad");
    check("bad_no_mem_valid", valid_cycles, vc0);
    push_bus(32'h10000004, 32'h12345678, 4'hF, 1'b1);
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h10000004, 1'b1, 32'h12345678);
    wait_idle("after_bad");
    check("overrun_clear", {31'h0, overrun}, 32'h0);

    // Stalled reply with an injected rx byte.
    rsp_lat = 2;
    rsp_data = 32'hCAFEF00D;
    tx_ready = 1'b0;
    push_bus(32'h00000020, 32'h0, 4'h0, 1'b0);
    push_tx_word(32'hCAFEF00D);
    send_frame(8'h52, 32'h00000020, 1'b0, 32'h0);
    wait_tx_valid("stall");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rx_data  = 8'h33;
      rx_valid = (i == 5);
      check("stall_tx_data", {24'h0, tx_data}, 32'h000000CA);
      check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
    end
    rx_valid = 1'b0;
    check("stall_overrun", {31'h0, overrun}, 32'h1);
    tx_ready = 1'b1;
    wait_idle("stall");

    // Reset while the bus request is outstanding.
    rsp_en = 1'b0;
    send_frame(8'h52, 32'h00000030, 1'b0, 32'h0);
    check("hang_valid", {31'h0, mem_valid}, 32'h1);
    repeat (3) @(posedge clk);
    pulse_reset();
    check_reset_state("rst_bus");
    rsp_en = 1'b1;

    // Reset in the middle of a reply.
    rsp_lat = 0;
    rsp_data = 32'h55AA55AA;
    tx_ready = 1'b0;
    push_bus(32'h00000040, 32'h0, 4'h0, 1'b0);
    send_frame(8'h52, 32'h00000040, 1'b0, 32'h0);
    wait_tx_valid("rst_resp");
    pulse_reset();
    check_reset_state("rst_resp");
    tx_ready = 1'b1;

    // Normal write after reset.
    push_bus(32'h10000000, 32'h12345678, 4'hF, 1'b1);
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h10000000, 1'b1, 32'h12345678);
    wait_idle("post_rst");

`ifdef UART_BUS_MASTER_BUS_TIMEOUT_EN
    // No responder: request must give up after 16 cycles with a NAK.
    rsp_en = 1'b0;
    exp_tx.push_back(8'h15);
    send_frame(8'h52, 32'h00000050, 1'b0, 32'h0);
    cnt = 0;
    while (mem_valid && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("tmo_valid_cycles", cnt, 16);
    wait_idle("tmo");
    rsp_en = 1'b1;

    // mem_ready in the terminal cycle wins.
    rsp_lat = 15;
    rsp_data = 32'h0BADF00D;
    push_bus(32'h00000060, 32'h0, 4'h0, 1'b0);
    push_tx_word(32'h0BADF00D);
    send_frame(8'h52, 32'h00000060, 1'b0, 32'h0);
    wait_idle("tmo_tie");
`else
    cnt = 0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("tx_queue_drained", exp_tx.size(), 0);
    check("bus_queue_drained", exp_bus.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
